// File: rtl/instr_prefetch_decoder.sv
// instr_prefetch_decoder
//
// Purpose: takes 16-bit instruction words from fetch over a valid/ready
// handshake, assembles one- or two-word instructions (group 5 spans two
// words), classifies the instruction group from the first word and tags
// each instruction with the word address of its first word. Assembled
// instructions are buffered in a FIFO_DEPTH-entry FIFO for execute.
//
// Parameters:
//   FIFO_DEPTH  buffered instructions (power of two, >= 2)
//   ADDR_WIDTH  width of the word-addressed PC
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   in_valid/in_word/in_ready  fetch word handshake (in_ready registered)
//   flush, flush_pc         drop all buffered/partial state, restart PC
//   out_valid/out_ready     FIFO head handshake
//   out_group/out_raw/out_two_word/out_pc  head instruction fields
//   fifo_count              FIFO occupancy
//   illegal_trap            only with INSTR_PREFETCH_ILLEGAL_TRAP_EN defined
//
// Optional feature: define INSTR_PREFETCH_ILLEGAL_TRAP_EN to stop accepting
// words after an unknown-group instruction and raise illegal_trap once it
// reaches the head; flush or reset clears the trap.

module instr_prefetch_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  input  logic [15:0]                     in_word,
  output logic                            in_ready,
  input  logic                            flush,
  input  logic [ADDR_WIDTH-1:0]           flush_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2:0]                      out_group,
  output logic [31:0]                     out_raw,
  output logic                            out_two_word,
  output logic [ADDR_WIDTH-1:0]           out_pc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
`ifdef INSTR_PREFETCH_ILLEGAL_TRAP_EN
  ,
  output logic                            illegal_trap
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  typedef enum logic {ST_FIRST, ST_WAIT_SECOND} state_t;

  typedef struct packed {
    logic [2:0]            group;
    logic [31:0]           raw;
    logic                  twoWord;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [15:0]           r_partialWord;
  logic [ADDR_WIDTH-1:0] r_partialPc;
  logic                  r_inReady;
  entry_t                r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_countNext;
  logic [2:0]            w_wordGroup;
  logic                  w_wordXfer;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_blocked;
  entry_t                w_pushEntry;
  entry_t                w_head;

  function automatic logic [2:0] classifyGroup(input logic [15:0] word);
    if (!word[15])                      return 3'd1;
    else if (word[15:14] == 2'b10)      return 3'd2;
    else if (word[15:12] == 4'b1100)    return 3'd3;
    else if (word[15:12] == 4'b1101)    return 3'd4;
    else if (word[15:10] == 6'b111000)  return 3'd5;
    else                                return 3'd0;
  endfunction

`ifdef INSTR_PREFETCH_ILLEGAL_TRAP_EN
  logic r_trapPending;
  logic r_trapLatched;
  logic w_trapAtHead;

  // No pushes follow the unknown entry, so once occupancy is one it is the head.
  assign w_trapAtHead = r_trapPending && (r_count == CNT_W'(1));
  assign w_blocked    = r_trapPending;
  assign illegal_trap = r_trapLatched || w_trapAtHead;

  // Trap bookkeeping: armed by pushing an unknown-group word, cleared by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trapPending <= 1'b0;
      r_trapLatched <= 1'b0;
    end else if (flush) begin
      r_trapPending <= 1'b0;
      r_trapLatched <= 1'b0;
    end else begin
      if (w_push && w_pushEntry.group == 3'd0) r_trapPending <= 1'b1;
      if (w_trapAtHead) r_trapLatched <= 1'b1;
    end
  end
`else
  assign w_blocked = 1'b0;
`endif

  // Flush gates in_ready combinationally so the flush cycle itself is closed.
  assign in_ready   = r_inReady && !flush && !w_blocked;
  assign w_wordXfer = in_valid && in_ready;
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready && !flush;
  assign fifo_count = r_count;

  // Assembly: decide what (if anything) gets pushed and the next state.
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    w_pushEntry = '0;
    w_wordGroup = classifyGroup(in_word);
    case (r_state)
      ST_FIRST: begin
        if (w_wordXfer) begin
          if (w_wordGroup == 3'd5) begin
            w_nextState = ST_WAIT_SECOND;
          end else begin
            w_push              = 1'b1;
            w_pushEntry.group   = w_wordGroup;
            w_pushEntry.raw     = {in_word, 16'h0000};
            w_pushEntry.twoWord = 1'b0;
            w_pushEntry.pc      = r_pc;
          end
        end
      end
      ST_WAIT_SECOND: begin
        if (w_wordXfer) begin
          w_push              = 1'b1;
          w_pushEntry.group   = 3'd5;
          w_pushEntry.raw     = {r_partialWord, in_word};
          w_pushEntry.twoWord = 1'b1;
          w_pushEntry.pc      = r_partialPc;
          w_nextState         = ST_FIRST;
        end
      end
      default: w_nextState = ST_FIRST;
    endcase
    if (flush) begin
      w_nextState = ST_FIRST;
      w_push      = 1'b0;
    end
    w_countNext = flush ? '0 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));
  end

  // Assembly state, PC and the partial register for the first group-5 word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_FIRST;
      r_pc          <= '0;
      r_partialWord <= '0;
      r_partialPc   <= '0;
    end else if (flush) begin
      r_state       <= ST_FIRST;
      r_pc          <= flush_pc;
      r_partialWord <= '0;
      r_partialPc   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_wordXfer) begin
        r_pc <= r_pc + ADDR_WIDTH'(1);
        if (r_state == ST_FIRST && w_wordGroup == 3'd5) begin
          r_partialWord <= in_word;
          r_partialPc   <= r_pc;
        end
      end
    end
  end

  // FIFO pointers, occupancy and the registered ready based on next occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_inReady <= 1'b0;
    end else begin
      r_count   <= w_countNext;
      r_inReady <= !flush && (w_countNext < CNT_W'(FIFO_DEPTH));
      if (flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
        if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= w_pushEntry;
  end

  assign w_head       = out_valid ? r_mem[r_rdPtr] : '0;
  assign out_group    = w_head.group;
  assign out_raw      = w_head.raw;
  assign out_two_word = w_head.twoWord;
  assign out_pc       = w_head.pc;

endmodule
